// File: rtl/dds_sweep_controller.sv
// dds_sweep_controller: emits a linear tuning-word sweep over a valid/ready port to the DDS
module dds_sweep_controller #(
  parameter int PHASE_WIDTH = 32,
  parameter int COUNT_WIDTH = 16,
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [PHASE_WIDTH-1:0] cfg_start_word,
  input  logic [PHASE_WIDTH-1:0] cfg_step_word,
  input  logic [COUNT_WIDTH-1:0] cfg_num_steps,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_loop,
  input  logic                   sweep_start,
  input  logic                   sweep_abort,
  output logic [PHASE_WIDTH-1:0] tw_tdata,
  output logic                   tw_tvalid,
  input  logic                   tw_tready,
  output logic                   tw_tuser,
  output logic [COUNT_WIDTH-1:0] step_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  typedef enum logic [1:0] {IDLE, ISSUE, DWELL} state_t;
  state_t                 state_q;
  logic [PHASE_WIDTH-1:0] start_q, step_q, tdata_q;
  logic [COUNT_WIDTH-1:0] num_q, idx_q;
  logic [DWELL_WIDTH-1:0] dwell_q, cnt_q;
  logic                   loop_q, tuser_q, done_q, err_q;
  logic [DWELL_WIDTH-1:0] dwell_d;
  logic                   last_d;
  assign dwell_d   = cfg_dwell == '0 ? DWELL_WIDTH'(1) : cfg_dwell;
  assign last_d    = idx_q == num_q - COUNT_WIDTH'(1);
  assign tw_tdata  = tdata_q;
  assign tw_tvalid = state_q == ISSUE;
  assign tw_tuser  = tuser_q && state_q == ISSUE;
  assign step_idx  = idx_q;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign err       = err_q;
  // sweep sequencer: start/abort handling, word issue, dwell countdown and pass wrap
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      start_q <= '0;
      step_q  <= '0;
      tdata_q <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      loop_q  <= 1'b0;
      tuser_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (sweep_abort) state_q <= IDLE;
      else case (state_q)
        IDLE: if (sweep_start) begin
          if (cfg_num_steps == '0) err_q <= 1'b1;
          else begin
            start_q <= cfg_start_word;
            step_q  <= cfg_step_word;
            num_q   <= cfg_num_steps;
            dwell_q <= dwell_d;
            loop_q  <= cfg_loop;
            tdata_q <= cfg_start_word;
            idx_q   <= '0;
            tuser_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: if (tw_tready) begin
          cnt_q   <= dwell_q;
          state_q <= DWELL;
        end
        DWELL: if (cnt_q != DWELL_WIDTH'(1)) cnt_q <= cnt_q - DWELL_WIDTH'(1);
        else if (!last_d) begin
          tdata_q <= tdata_q + step_q;
          idx_q   <= idx_q + COUNT_WIDTH'(1);
          tuser_q <= 1'b0;
          state_q <= ISSUE;
        end else if (loop_q) begin
          tdata_q <= start_q;
          idx_q   <= '0;
          tuser_q <= 1'b1;
          state_q <= ISSUE;
        end else begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb_dds_sweep_controller: directed table and sequence checks of the sweep controller
module tb_dds_sweep_controller;
  logic        ACLK, ARESETN;
  logic [31:0] cfg_start_word, cfg_step_word;
  logic [15:0] cfg_num_steps;
  logic [23:0] cfg_dwell;
  logic        cfg_loop, sweep_start, sweep_abort, tw_tready;
  logic [31:0] tw_tdata;
  logic        tw_tvalid, tw_tuser, busy, done, err;
  logic [15:0] step_idx;
  int          n_pass = 0, n_total = 0, n_rows = 0;
  typedef struct {
    logic        st, ab, rdy, v;
    logic [31:0] d;
    logic        u;
    logic [15:0] i;
    logic        b, dn, e;
  } vec_t;
  vec_t tbl[32];
  dds_sweep_controller dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cfg_start_word(cfg_start_word), .cfg_step_word(cfg_step_word),
    .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
    .sweep_start(sweep_start), .sweep_abort(sweep_abort),
    .tw_tdata(tw_tdata), .tw_tvalid(tw_tvalid), .tw_tready(tw_tready), .tw_tuser(tw_tuser),
    .step_idx(step_idx), .busy(busy), .done(done), .err(err)
  );
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [31:0] d, input logic u,
                         input logic [15:0] i, input logic b, input logic dn, input logic e);
    chk($sformatf("%s tvalid", tag), 32'(tw_tvalid), 32'(v));
    chk($sformatf("%s tdata", tag), tw_tdata, d);
    chk($sformatf("%s tuser", tag), 32'(tw_tuser), 32'(u));
    chk($sformatf("%s step_idx", tag), 32'(step_idx), 32'(i));
    chk($sformatf("%s busy", tag), 32'(busy), 32'(b));
    chk($sformatf("%s done", tag), 32'(done), 32'(dn));
    chk($sformatf("%s err", tag), 32'(err), 32'(e));
  endtask
  task automatic set_cfg(input logic [31:0] s, input logic [31:0] st, input logic [15:0] n,
                         input logic [23:0] dw, input logic lp);
    cfg_start_word = s;
    cfg_step_word  = st;
    cfg_num_steps  = n;
    cfg_dwell      = dw;
    cfg_loop       = lp;
  endtask
  task automatic add(input logic st, input logic ab, input logic rdy, input logic v, input logic [31:0] d,
                     input logic u, input logic [15:0] i, input logic b, input logic dn, input logic e);
    tbl[n_rows] = '{st, ab, rdy, v, d, u, i, b, dn, e};
    n_rows++;
  endtask
  task automatic run_rows(input string tag, input int a, input int z);
    for (int r = a; r < z; r++) begin
      sweep_start = tbl[r].st;
      sweep_abort = tbl[r].ab;
      tw_tready   = tbl[r].rdy;
      chk_out($sformatf("%s c%0d", tag, r - a), tbl[r].v, tbl[r].d, tbl[r].u, tbl[r].i,
              tbl[r].b, tbl[r].dn, tbl[r].e);
      tick();
    end
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
  endtask
  task automatic run_two(input string tag, input logic [31:0] s, input logic [31:0] st,
                         input logic [31:0] w0, input logic [31:0] w1);
    set_cfg(s, st, 16'd2, 24'd1, 1'b0);
    tw_tready = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk($sformatf("%s w0 tvalid", tag), 32'(tw_tvalid), 32'd1);
    chk($sformatf("%s w0", tag), tw_tdata, w0);
    tick();
    tick();
    chk($sformatf("%s w1 tvalid", tag), 32'(tw_tvalid), 32'd1);
    chk($sformatf("%s w1", tag), tw_tdata, w1);
    tick();
    tick();
    chk($sformatf("%s done", tag), 32'(done), 32'd1);
  endtask
  initial begin
    // scenario 1: basic sweep, start in cycle 0
    add(1,0,1, 0,32'h0000,0,0,0,0,0);
    add(0,0,1, 1,32'h1000,1,0,1,0,0);
    add(0,0,1, 0,32'h1000,0,0,1,0,0);
    add(0,0,1, 0,32'h1000,0,0,1,0,0);
    add(0,0,1, 1,32'h1100,0,1,1,0,0);
    add(0,0,1, 0,32'h1100,0,1,1,0,0);
    add(0,0,1, 0,32'h1100,0,1,1,0,0);
    add(0,0,1, 1,32'h1200,0,2,1,0,0);
    add(0,0,1, 0,32'h1200,0,2,1,0,0);
    add(0,0,1, 0,32'h1200,0,2,1,0,0);
    add(0,0,1, 0,32'h1200,0,2,0,1,0);
    add(0,0,1, 0,32'h1200,0,2,0,0,0);
    // scenario 4: looping sweep N=2 dwell=1, abort in DWELL
    add(1,0,1, 0,32'h1200,0,2,0,0,0);
    add(0,0,1, 1,32'h0100,1,0,1,0,0);
    add(0,0,1, 0,32'h0100,0,0,1,0,0);
    add(0,0,1, 1,32'h0110,0,1,1,0,0);
    add(0,0,1, 0,32'h0110,0,1,1,0,0);
    add(0,0,1, 1,32'h0100,1,0,1,0,0);
    add(0,1,1, 0,32'h0100,0,0,1,0,0);
    add(0,0,1, 0,32'h0100,0,0,0,0,0);
    add(0,0,1, 0,32'h0100,0,0,0,0,0);
    ARESETN = 1'b0;
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
    tw_tready = 1'b0;
    set_cfg(32'h1000, 32'h100, 16'd3, 24'd2, 1'b0);
    tick();
    tick();
    chk_out("reset", 0, 32'h0, 0, 16'h0, 0, 0, 0);
    #2 ARESETN = 1'b1;
    tick();
    chk_out("post reset", 0, 32'h0, 0, 16'h0, 0, 0, 0);
    run_rows("basic", 0, 12);
    set_cfg(32'h100, 32'h10, 16'd2, 24'd1, 1'b1);
    run_rows("loop", 12, 21);
    // backpressure on second word
    set_cfg(32'h1000, 32'h100, 16'd3, 24'd2, 1'b0);
    tw_tready = 1'b1;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    tick();
    tick();
    tw_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp tvalid", 32'(tw_tvalid), 32'd1);
      chk("bp tdata", tw_tdata, 32'h1100);
      chk("bp idx", 32'(step_idx), 32'd1);
      tick();
    end
    tw_tready = 1'b1;
    chk("bp hs tvalid", 32'(tw_tvalid), 32'd1);
    tick();
    chk("bp dwell1", 32'(tw_tvalid), 32'd0);
    tick();
    chk("bp dwell2", 32'(tw_tvalid), 32'd0);
    tick();
    chk("bp w2 tvalid", 32'(tw_tvalid), 32'd1);
    chk("bp w2 tdata", tw_tdata, 32'h1200);
    tick();
    tick();
    tick();
    chk("bp done", 32'(done), 32'd1);
    chk("bp busy", 32'(busy), 32'd0);
    // wrap-around and negative step
    run_two("wrap", 32'hFFFFFF00, 32'h100, 32'hFFFFFF00, 32'h0);
    run_two("neg", 32'h0, 32'hFFFFFF00, 32'h0, 32'hFFFFFF00);
    // N=0 rejected
    set_cfg(32'h5000, 32'h1, 16'd0, 24'd1, 1'b0);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("n0 err", 32'(err), 32'd1);
    chk("n0 tvalid", 32'(tw_tvalid), 32'd0);
    tick();
    chk("n0 err pulse", 32'(err), 32'd0);
    chk("n0 tvalid later", 32'(tw_tvalid), 32'd0);
    chk("n0 busy", 32'(busy), 32'd0);
    // start ignored while busy, cfg changes isolated
    set_cfg(32'h1000, 32'h100, 16'd3, 24'd2, 1'b0);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    set_cfg(32'h9999, 32'h5, 16'd0, 24'd7, 1'b1);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    chk("iso err", 32'(err), 32'd0);
    tick();
    chk("iso w1 tvalid", 32'(tw_tvalid), 32'd1);
    chk("iso w1", tw_tdata, 32'h1100);
    tick();
    tick();
    tick();
    chk("iso w2", tw_tdata, 32'h1200);
    chk("iso w2 tvalid", 32'(tw_tvalid), 32'd1);
    tick();
    tick();
    tick();
    chk("iso done", 32'(done), 32'd1);
    // start and abort together
    set_cfg(32'h1000, 32'h100, 16'd3, 24'd2, 1'b0);
    sweep_start = 1'b1;
    sweep_abort = 1'b1;
    tick();
    sweep_start = 1'b0;
    sweep_abort = 1'b0;
    chk("sa busy", 32'(busy), 32'd0);
    chk("sa tvalid", 32'(tw_tvalid), 32'd0);
    chk("sa err", 32'(err), 32'd0);
    // abort in the handshake cycle
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    sweep_abort = 1'b1;
    tick();
    sweep_abort = 1'b0;
    chk_out("hs abort", 0, 32'h1000, 0, 16'h0, 0, 0, 0);
    tick();
    chk("hs abort done", 32'(done), 32'd0);
    // asynchronous reset in DWELL
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    #2 ARESETN = 1'b0;
    #1 chk_out("async rst", 0, 32'h0, 0, 16'h0, 0, 0, 0);
    #2 ARESETN = 1'b1;
    tick();
    chk_out("rst release", 0, 32'h0, 0, 16'h0, 0, 0, 0);
    // dwell=0 behaves as dwell=1
    set_cfg(32'h1000, 32'h100, 16'd3, 24'd0, 1'b0);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d0 w%0d tvalid", k), 32'(tw_tvalid), 32'd1);
      chk($sformatf("d0 w%0d", k), tw_tdata, 32'h1000 + 32'(k) * 32'h100);
      tick();
      chk($sformatf("d0 gap%0d", k), 32'(tw_tvalid), 32'd0);
      tick();
    end
    chk("d0 done", 32'(done), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dds_sweep_controller.md
Name: dds_sweep_controller

Overview:
- Sequencer that drives the tuning-word (phase increment) update port of the tunable DDS.
- Emits a programmed linear frequency sweep over an AXI4-Stream-style valid/ready port: start word, signed step, N words, each held for a programmed dwell.
- Supports single-pass and looping sweeps.
- Sits between the AXI4-Lite register file (cfg/cmd fields) and the DDS phase accumulator.

Parameters:
- PHASE_WIDTH, 32, width of the tuning word and step.
- COUNT_WIDTH, 16, width of the step count and index.
- DWELL_WIDTH, 24, width of the dwell counter.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset, asynchronous, active-low.
- cfg_start_word  in  PHASE_WIDTH  first tuning word.
- cfg_step_word  in  PHASE_WIDTH  two's-complement increment per step.
- cfg_num_steps  in  COUNT_WIDTH  words per sweep pass; 0 is illegal.
- cfg_dwell  in  DWELL_WIDTH  hold cycles after each accepted word; 0 is treated as 1.
- cfg_loop  in  1  1 = restart the pass after the last word.
- sweep_start  in  1  single-cycle start command.
- sweep_abort  in  1  single-cycle abort command.
- tw_tdata  out  PHASE_WIDTH  tuning word to the DDS.
- tw_tvalid  out  1  tuning word valid.
- tw_tready  in  1  DDS accepts the word.
- tw_tuser  out  1  high with the first word of each pass (DDS phase reset).
- step_idx  out  COUNT_WIDTH  index of the current word.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when a single-pass sweep completes.
- err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset: ARESETN low drives all outputs to 0 and the state to IDLE immediately (asynchronously). All registers are released synchronously to ACLK.
- States:
  - IDLE: busy=0, tw_tvalid=0.
  - ISSUE: tw_tvalid=1.
  - DWELL: tw_tvalid=0, counting down the dwell.
- IDLE, sweep_start=1 and cfg_num_steps!=0:
  - Latch all cfg_* into shadow registers.
  - tw_tdata<=start, step_idx<=0, tw_tuser<=1.
  - Go to ISSUE; tw_tvalid is high in the next cycle (latency 1).
- IDLE, sweep_start=1 and cfg_num_steps==0: err=1 for one cycle; stay in IDLE.
- cfg_* changes after the latch have no effect until the next accepted start.
- ISSUE:
  - tw_tdata and tw_tuser stay stable while tw_tvalid=1 and tw_tready=0.
  - On handshake, load the dwell counter with D=max(cfg_dwell,1) and go to DWELL.
  - The first handshake cycle of a word is not counted in the dwell.
- DWELL: exactly D cycles. In the last DWELL cycle, update registers for the next cycle:
  - If step_idx<N-1: tw_tdata<=tw_tdata+step (modulo 2^PHASE_WIDTH, wrap-around allowed), step_idx++, tw_tuser<=0, go to ISSUE.
  - If step_idx==N-1 and loop=1: tw_tdata<=start, step_idx<=0, tw_tuser<=1, go to ISSUE.
  - If step_idx==N-1 and loop=0: go to IDLE; done=1 in that next cycle with busy=0.
- Timing: a handshake in cycle h puts the next tw_tvalid in cycle h+D+1.
- busy: 1 in every ISSUE/DWELL cycle, 0 otherwise.
- sweep_start while busy: ignored, no err.
- sweep_abort:
  - Any state: go to IDLE next cycle. tw_tvalid drops even without a handshake; an aborted update is discarded by the DDS by design.
  - No done pulse on abort.
  - step_idx and tw_tdata hold their last values.
- sweep_start and sweep_abort in the same cycle: abort wins; no sweep starts, no err.
- Abort in the same cycle as a handshake: the word counts as delivered; the next state is still IDLE.

Test Plan:
1. Basic sweep: start=0x00001000, step=0x00000100, N=3, dwell=2, loop=0, tready=1, start in cycle 0.
   - Required: tvalid in cycles 1, 4, 7 with data 0x1000, 0x1100, 0x1200.
   - tuser=1 only in cycle 1.
   - busy high in cycles 1-9; done pulse in cycle 10.
2. Backpressure: as scenario 1, tready=0 for 5 cycles when the second word appears.
   - Required: tdata held at 0x1100 with tvalid high throughout.
   - Third word appears 3 cycles after the handshake; step_idx=1 while stalled.
3. Wrap and negative step:
   - start=0xFFFFFF00, step=0x100, N=2 -> words 0xFFFFFF00 then 0x00000000.
   - start=0, step=0xFFFFFF00 -> words 0x0 then 0xFFFFFF00.
4. Loop and abort: N=2, loop=1, dwell=1.
   - Required: words repeat start, start+step, start, ...; tuser high on every pass's first word.
   - sweep_abort mid-DWELL -> busy and tvalid 0 in the next cycle, no done.
5. Rejects and config isolation:
   - N=0 with start -> err for exactly 1 cycle, tvalid never rises.
   - sweep_start during a sweep -> ignored.
   - Changing cfg_step_word mid-sweep -> words unchanged.
   - start+abort in the same cycle -> stays IDLE.
6. Reset and dwell edge cases:
   - ARESETN asserted mid-DWELL -> all outputs 0 before the next clock edge; after release the block is IDLE.
   - dwell=0 -> same timing as dwell=1 (tvalid every 2 cycles with tready=1).
